// File: rtl/avg_pkg.sv
// Shared sizing defaults and arithmetic helpers for the averaging datapath.
//   BRAM_WIDTH_DEF / DATA_WIDTH_DEF : default address and sample widths
//   acc_width()                     : accumulator word width from address and sample widths
//   sext()                          : sign-extend the low from_w bits of a wide vector
package avg_pkg;

   localparam int unsigned BRAM_WIDTH_DEF = 5;
   localparam int unsigned DATA_WIDTH_DEF = 14;
   localparam int unsigned SEXT_MAX_W     = 64;

   // Headroom for 2**bram_w passes of full-scale samples.
   function automatic int unsigned acc_width(input int unsigned bram_w,
                                             input int unsigned data_w);
      return data_w + bram_w;
   endfunction

   // Replicates bit from_w-1 into all higher bits; callers truncate to their width.
   function automatic logic [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] x,
                                                  input int unsigned           from_w);
      logic [SEXT_MAX_W-1:0] r;
      r = x;
      for (int unsigned i = 0; i < SEXT_MAX_W; i++) begin
         if (i >= from_w) r[i] = x[from_w-1];
      end
      return r;
   endfunction

endpackage

// File: rtl/acc_sum.sv
// Read-modify-write adder for the averaging BRAM.
//   init   : first pass, store the sample instead of adding
//   din    : signed sample
//   stored : word read back from the BRAM
//   sum_c  : combinational result, wraps modulo 2**ACC_WIDTH
module acc_sum
   import avg_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned ACC_WIDTH  = acc_width(BRAM_WIDTH_DEF, DATA_WIDTH_DEF)
) (
   input  logic                  init,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic [ACC_WIDTH-1:0]  stored,
   output logic [ACC_WIDTH-1:0]  sum_c
);

   logic [ACC_WIDTH-1:0] din_ext;

   // Two's-complement add of equal widths gives the required modular wrap.
   always_comb begin
      din_ext = ACC_WIDTH'(sext(SEXT_MAX_W'(din), DATA_WIDTH));
      sum_c   = init ? din_ext : stored + din_ext;
   end

endmodule

// File: rtl/bram_accumulator.sv
// Accumulating read-modify-write stage in front of a simple dual-port BRAM.
//   clk, rstn                : clock, asynchronous active-low reset
//   din, address             : sample and its BRAM address (same cycle)
//   wen, init, count         : write enable, first-pass flag, pass counter
//   bram_rdaddr              : read address (combinational copy of address)
//   bram_rddata              : read data, valid one cycle after bram_rdaddr
//   bram_wraddr/wrdata/we    : registered write port
//   pass_done                : one-cycle pulse after a write burst ends
//   n_avg                    : pass counter of the last sample of the finished burst
module bram_accumulator
   import avg_pkg::*;
#(
   parameter int unsigned BRAM_WIDTH = BRAM_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned ACC_WIDTH  = acc_width(BRAM_WIDTH, DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic [BRAM_WIDTH-1:0] address,
   input  logic                  wen,
   input  logic                  init,
   input  logic [BRAM_WIDTH-1:0] count,
   output logic [BRAM_WIDTH-1:0] bram_rdaddr,
   input  logic [ACC_WIDTH-1:0]  bram_rddata,
   output logic [BRAM_WIDTH-1:0] bram_wraddr,
   output logic [ACC_WIDTH-1:0]  bram_wrdata,
   output logic                  bram_we,
   output logic                  pass_done,
   output logic [BRAM_WIDTH-1:0] n_avg
);

   logic [DATA_WIDTH-1:0] s1_din;
   logic [BRAM_WIDTH-1:0] s1_address;
   logic                  s1_wen;
   logic                  s1_init;
   logic [BRAM_WIDTH-1:0] s1_count;
   logic [BRAM_WIDTH-1:0] s2_count;
   logic                  we_d;
   logic [ACC_WIDTH-1:0]  sum_c;

   // Read is issued in the sample cycle so the data lines up with stage 1.
   assign bram_rdaddr = address;

   // Stage 1: align the sample with the BRAM read latency.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_din     <= '0;
         s1_address <= '0;
         s1_wen     <= 1'b0;
         s1_init    <= 1'b0;
         s1_count   <= '0;
      end else begin
         s1_din     <= din;
         s1_address <= address;
         s1_wen     <= wen;
         s1_init    <= init;
         s1_count   <= count;
      end
   end

   acc_sum #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_acc_sum (
      .init   (s1_init),
      .din    (s1_din),
      .stored (bram_rddata),
      .sum_c  (sum_c)
   );

   // Stage 2: write port registers; s2_count holds the count of the last written sample.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bram_wraddr <= '0;
         bram_wrdata <= '0;
         bram_we     <= 1'b0;
         s2_count    <= '0;
      end else begin
         bram_wraddr <= s1_address;
         bram_wrdata <= sum_c;
         bram_we     <= s1_wen;
         if (s1_wen) s2_count <= s1_count;
      end
   end

   // Burst end: pulse one cycle after bram_we falls, latching the pass count.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         we_d      <= 1'b0;
         pass_done <= 1'b0;
         n_avg     <= '0;
      end else begin
         we_d      <= bram_we;
         pass_done <= we_d & ~bram_we;
         if (we_d & ~bram_we) n_avg <= s2_count;
      end
   end

endmodule

// File: tb/tb_bram_accumulator.sv
// Directed self-checking bench for bram_accumulator with a 1-cycle-latency BRAM model.
module tb_bram_accumulator;

   localparam int unsigned BW    = 3;
   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 11;
   localparam int unsigned DEPTH = 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic [DW-1:0] din;
   logic [BW-1:0] address;
   logic          wen;
   logic          init;
   logic [BW-1:0] count;
   logic [BW-1:0] bram_rdaddr;
   logic [AW-1:0] bram_rddata;
   logic [BW-1:0] bram_wraddr;
   logic [AW-1:0] bram_wrdata;
   logic          bram_we;
   logic          pass_done;
   logic [BW-1:0] n_avg;

   logic [AW-1:0] mem [DEPTH];
   logic          poke;
   logic [BW-1:0] poke_addr;
   logic [AW-1:0] poke_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bram_accumulator #(
      .BRAM_WIDTH (BW),
      .DATA_WIDTH (DW),
      .ACC_WIDTH  (AW)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .din         (din),
      .address     (address),
      .wen         (wen),
      .init        (init),
      .count       (count),
      .bram_rdaddr (bram_rdaddr),
      .bram_rddata (bram_rddata),
      .bram_wraddr (bram_wraddr),
      .bram_wrdata (bram_wrdata),
      .bram_we     (bram_we),
      .pass_done   (pass_done),
      .n_avg       (n_avg)
   );

   // BRAM model: registered read, write at the clock edge; poke preloads a word.
   always @(posedge clk) begin
      bram_rddata <= mem[bram_rdaddr];
      if (bram_we) mem[bram_wraddr] <= bram_wrdata;
      if (poke) mem[poke_addr] <= poke_data;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic i, input logic [BW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] c);
      wen = w; init = i; address = a; din = d; count = c;
   endtask

   task automatic test_reset();
      rstn = 1'b1;
      poke = 1'b0; poke_addr = '0; poke_data = '0;
      drive(1'b0, 1'b0, '0, '0, '0);
      #2 rstn = 1'b0;
      #1;
      n_checks++; if (bram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0h expected 0", bram_we); end
      n_checks++; if (bram_wrdata !== '0) begin n_fail++; $display("FAIL reset_wrdata: got %0h expected 0", bram_wrdata); end
      n_checks++; if (bram_wraddr !== '0) begin n_fail++; $display("FAIL reset_wraddr: got %0h expected 0", bram_wraddr); end
      n_checks++; if (pass_done !== 1'b0) begin n_fail++; $display("FAIL reset_pass_done: got %0h expected 0", pass_done); end
      n_checks++; if (n_avg !== '0) begin n_fail++; $display("FAIL reset_n_avg: got %0h expected 0", n_avg); end
      step(); step();
      rstn = 1'b1;
      step(); step();
   endtask

   task automatic test_init_pass();
      int k;
      int we_cnt = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (cyc < 8) drive(1'b1, 1'b1, BW'(cyc), DW'(cyc + 1), 3'd3);
         else         drive(1'b0, 1'b0, '0, '0, '0);
         step();
         k = cyc - 1;
         if (bram_we) we_cnt++;
         n_checks++; if (bram_we !== (k >= 0 && k < 8)) begin n_fail++; $display("FAIL init_we cyc%0d: got %0h expected %0h", cyc, bram_we, (k >= 0 && k < 8)); end
         if (k >= 0 && k < 8) begin
            n_checks++; if (bram_wraddr !== BW'(k)) begin n_fail++; $display("FAIL init_wraddr cyc%0d: got %0h expected %0h", cyc, bram_wraddr, BW'(k)); end
            n_checks++; if (bram_wrdata !== AW'(k + 1)) begin n_fail++; $display("FAIL init_wrdata cyc%0d: got %0h expected %0h", cyc, bram_wrdata, AW'(k + 1)); end
         end
         n_checks++; if (pass_done !== (k == 9)) begin n_fail++; $display("FAIL init_pass_done cyc%0d: got %0h expected %0h", cyc, pass_done, (k == 9)); end
         if (k == 9) begin
            n_checks++; if (n_avg !== 3'd3) begin n_fail++; $display("FAIL init_n_avg: got %0h expected 3", n_avg); end
         end
      end
      n_checks++; if (we_cnt != 8) begin n_fail++; $display("FAIL init_we_count: got %0d expected 8", we_cnt); end
   endtask

   task automatic test_accumulate();
      int k;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (cyc < 8) drive(1'b1, 1'b0, BW'(cyc), 8'hFF, 3'd4);
         else         drive(1'b0, 1'b0, '0, '0, 3'd6);
         step();
         k = cyc - 1;
         n_checks++; if (bram_we !== (k >= 0 && k < 8)) begin n_fail++; $display("FAIL acc_we cyc%0d: got %0h expected %0h", cyc, bram_we, (k >= 0 && k < 8)); end
         if (k >= 0 && k < 8) begin
            n_checks++; if (bram_wrdata !== AW'(k)) begin n_fail++; $display("FAIL acc_wrdata cyc%0d: got %0h expected %0h", cyc, bram_wrdata, AW'(k)); end
         end
         n_checks++; if (pass_done !== (k == 9)) begin n_fail++; $display("FAIL acc_pass_done cyc%0d: got %0h expected %0h", cyc, pass_done, (k == 9)); end
         if (k == 9) begin
            n_checks++; if (n_avg !== 3'd4) begin n_fail++; $display("FAIL acc_n_avg: got %0h expected 4", n_avg); end
         end
      end
   endtask

   task automatic test_sign_ext();
      drive(1'b1, 1'b1, 3'd0, 8'h80, 3'd1);
      step();
      drive(1'b0, 1'b0, '0, '0, '0);
      step();
      n_checks++; if (bram_we !== 1'b1) begin n_fail++; $display("FAIL sext_init_we: got %0h expected 1", bram_we); end
      n_checks++; if (bram_wrdata !== 11'h780) begin n_fail++; $display("FAIL sext_init_wrdata: got %0h expected 780", bram_wrdata); end
      repeat (4) step();
      drive(1'b1, 1'b0, 3'd0, 8'h80, 3'd2);
      step();
      drive(1'b0, 1'b0, '0, '0, '0);
      step();
      n_checks++; if (bram_wrdata !== 11'h700) begin n_fail++; $display("FAIL sext_acc_wrdata: got %0h expected 700", bram_wrdata); end
      repeat (4) step();
   endtask

   task automatic test_overflow();
      poke = 1'b1; poke_addr = 3'd5; poke_data = 11'h3FF;
      step();
      poke = 1'b0;
      drive(1'b1, 1'b0, 3'd5, 8'h01, 3'd1);
      step();
      drive(1'b0, 1'b0, '0, '0, '0);
      step();
      n_checks++; if (bram_wraddr !== 3'd5) begin n_fail++; $display("FAIL ovf_wraddr: got %0h expected 5", bram_wraddr); end
      n_checks++; if (bram_wrdata !== 11'h400) begin n_fail++; $display("FAIL ovf_wrdata: got %0h expected 400", bram_wrdata); end
      repeat (4) step();
   endtask

   task automatic test_idle();
      for (int cyc = 0; cyc < 20; cyc++) begin
         drive(1'b0, 1'($urandom), BW'($urandom), DW'($urandom), BW'($urandom));
         step();
         n_checks++; if (bram_we !== 1'b0) begin n_fail++; $display("FAIL idle_we cyc%0d: got %0h expected 0", cyc, bram_we); end
         n_checks++; if (pass_done !== 1'b0) begin n_fail++; $display("FAIL idle_pass_done cyc%0d: got %0h expected 0", cyc, pass_done); end
      end
   endtask

   task automatic test_wrap();
      int k;
      for (int cyc = 0; cyc < 11; cyc++) begin
         if (cyc < 10) drive(1'b1, 1'b1, BW'(cyc + 4), DW'(cyc), 3'd1);
         else          drive(1'b0, 1'b0, '0, '0, '0);
         step();
         k = cyc - 1;
         if (k >= 0) begin
            n_checks++; if (bram_we !== 1'b1) begin n_fail++; $display("FAIL wrap_we cyc%0d: got %0h expected 1", cyc, bram_we); end
            n_checks++; if (bram_wraddr !== BW'(k + 4)) begin n_fail++; $display("FAIL wrap_wraddr cyc%0d: got %0h expected %0h", cyc, bram_wraddr, BW'(k + 4)); end
            n_checks++; if (pass_done !== 1'b0) begin n_fail++; $display("FAIL wrap_pass_done cyc%0d: got %0h expected 0", cyc, pass_done); end
         end
      end
      repeat (4) step();
   endtask

   task automatic test_reset_mid_pass();
      int k;
      for (int cyc = 0; cyc < 4; cyc++) begin
         drive(1'b1, 1'b1, BW'(cyc), DW'(cyc + 10), 3'd2);
         if (cyc < 3) step();
      end
      n_checks++; if (bram_we !== 1'b1) begin n_fail++; $display("FAIL mid_pre_we: got %0h expected 1", bram_we); end
      #2 rstn = 1'b0;
      #1;
      n_checks++; if (bram_we !== 1'b0) begin n_fail++; $display("FAIL mid_we: got %0h expected 0", bram_we); end
      n_checks++; if (bram_wrdata !== '0) begin n_fail++; $display("FAIL mid_wrdata: got %0h expected 0", bram_wrdata); end
      n_checks++; if (bram_wraddr !== '0) begin n_fail++; $display("FAIL mid_wraddr: got %0h expected 0", bram_wraddr); end
      n_checks++; if (pass_done !== 1'b0) begin n_fail++; $display("FAIL mid_pass_done: got %0h expected 0", pass_done); end
      drive(1'b0, 1'b0, '0, '0, '0);
      step(); step();
      rstn = 1'b1;
      for (int cyc = 0; cyc < 5; cyc++) begin
         step();
         n_checks++; if (pass_done !== 1'b0 || bram_we !== 1'b0) begin n_fail++; $display("FAIL mid_after_release cyc%0d: got pd=%0h we=%0h expected 0 0", cyc, pass_done, bram_we); end
      end
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (cyc < 8) drive(1'b1, 1'b1, BW'(cyc), DW'(2 * cyc + 3), 3'd5);
         else         drive(1'b0, 1'b0, '0, '0, '0);
         step();
         k = cyc - 1;
         if (k >= 0 && k < 8) begin
            n_checks++; if (bram_wrdata !== AW'(2 * k + 3)) begin n_fail++; $display("FAIL fresh_wrdata cyc%0d: got %0h expected %0h", cyc, bram_wrdata, AW'(2 * k + 3)); end
         end
         n_checks++; if (pass_done !== (k == 9)) begin n_fail++; $display("FAIL fresh_pass_done cyc%0d: got %0h expected %0h", cyc, pass_done, (k == 9)); end
         if (k == 9) begin
            n_checks++; if (n_avg !== 3'd5) begin n_fail++; $display("FAIL fresh_n_avg: got %0h expected 5", n_avg); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_init_pass();
      test_accumulate();
      test_sign_ext();
      test_overflow();
      test_idle();
      test_wrap();
      test_reset_mid_pass();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bram_accumulator.md
Name: bram_accumulator

Overview:
- Datapath stage directly downstream of the write-enable controller (wen/count/init).
- Performs the read-modify-write on the averaging BRAM: first pass after restart (init=1) stores the sample; later passes add the sample to the stored sum.
- Drives a simple dual-port BRAM: read port with 1-cycle registered output, plus a write port.
- Reports pass completion and the number of accumulated passes to the register bank.

Parameters:
- BRAM_WIDTH, 5, address width; depth = 2**BRAM_WIDTH; legal range >= 2.
- DATA_WIDTH, 14, signed input sample width.
- ACC_WIDTH, DATA_WIDTH+BRAM_WIDTH, accumulator/BRAM word width; must be >= DATA_WIDTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- din  in  DATA_WIDTH  signed sample, aligned with address.
- address  in  BRAM_WIDTH  sample address, same cycle as din.
- wen  in  1  write enable from write-enable stage.
- init  in  1  first-pass flag from write-enable stage.
- count  in  BRAM_WIDTH  pass counter from write-enable stage.
- bram_rdaddr  out  BRAM_WIDTH  read address; combinational copy of address.
- bram_rddata  in  ACC_WIDTH  read data; valid 1 cycle after bram_rdaddr.
- bram_wraddr  out  BRAM_WIDTH  registered write address.
- bram_wrdata  out  ACC_WIDTH  registered write data.
- bram_we  out  1  registered write strobe.
- pass_done  out  1  one-cycle pulse when a write burst ends.
- n_avg  out  BRAM_WIDTH  count value latched at pass_done.

Behaviour:
- Reset, asynchronous, while rstn=0: bram_wraddr, bram_wrdata, bram_we, pass_done, n_avg and all pipeline registers = 0.
- Stage 1, input at cycle n: register din, address, wen, init, count into s1_*.
- Stage 2, cycle n+1, bram_rddata valid:
  - sum = s1_init ? sext(s1_din) : bram_rddata + sext(s1_din).
  - Arithmetic is signed and wraps modulo 2**ACC_WIDTH; no saturation.
  - sext = sign extension of DATA_WIDTH to ACC_WIDTH.
- Output registers load sum, s1_address, s1_wen. Values are visible in cycle n+2, and the BRAM commits at the end of n+2.
- Latency: input to visible bram_we / bram_wrdata = 2 cycles.
- Read/write hazard:
  - The read of address a at cycle n+2**BRAM_WIDTH never overlaps the pending write of a, because BRAM_WIDTH>=2 and address increments by 1 per cycle.
  - No forwarding is implemented.
  - Non-incrementing address streams are unsupported.
- Wrap-around: address 2**BRAM_WIDTH-1 -> 0 with wen held high gives a continuous bram_we; no bubble.
- init with wen=0: no write; init has no other effect.
- pass_done:
  - Asserted for 1 cycle in the cycle after bram_we goes 1->0.
  - In that same cycle, n_avg <= count delayed to match the last written sample (s2_count).
- Reset mid-pass: pipeline flushed and bram_we drops immediately. BRAM contents for that pass are undefined. No pass_done is issued. Upstream must restart so that the next pass runs with init=1.
- pass_done is never asserted in the same cycle as bram_we=1 unless a new burst starts the cycle after the previous one ended. Both are legal and independent.

Decomposition:
- Package avg_pkg holds:
  - BRAM_WIDTH and DATA_WIDTH defaults;
  - the ACC_WIDTH derivation function;
  - the sext helper function.
- One sub-module: acc_sum (combinational/registered adder: init mux, sign extension, wrap add).
- Pipeline and pass_done logic live in the top.

Test Plan (BRAM_WIDTH=3, DATA_WIDTH=8, ACC_WIDTH=11, bench models the BRAM with 1-cycle read latency):
- Init pass: wen=1 and init=1 for 8 cycles, address 0..7, din=address+1.
  - Required: bram_we high for exactly 8 cycles starting 2 cycles later.
  - Required: wrdata 1..8 at wraddr 0..7.
  - Required: pass_done pulses once after the burst ends.
- Accumulate pass: repeat with init=0 and din=-1.
  - Required: wrdata 0..7.
  - Required: n_avg equals the count presented with the last sample.
- Sign extension: init=1, din=8'h80 -> wrdata=11'h780 (-128). Then init=0 with din=8'h80 again -> wrdata=11'h700 (-256).
- Overflow wrap: stored 11'h3FF, din=1, init=0 -> wrdata=11'h400 (signed wrap, no saturation).
- wen=0 for 20 cycles with random din/init -> bram_we=0 throughout and no pass_done.
- Reset mid-pass: deassert rstn at the 4th sample -> bram_we=0 and outputs zero immediately. No pass_done. After release, a fresh init pass writes correct values.
